// File: rtl/ddr_test_sequencer.sv
// DDR input throughput test sequencer: arms capture, locks onto a 5-bit XNOR LFSR
// pattern, then counts bit errors over test_len captures. Optional: DDR_SEQ_FIRST_ERR_EN.
module ddr_test_sequencer #(
  parameter int WIDTH        = 8,
  parameter int LEN_W        = 8,
  parameter int ERR_W        = 8,
  parameter int LOCK_CYCLES  = 4,
  parameter int LOCK_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] test_len,
  input  logic [WIDTH-1:0] cap_rise,
  input  logic [WIDTH-1:0] cap_fall,
  input  logic             cap_valid,
  output logic             cap_en,
  output logic             busy,
  output logic             done,
  output logic             locked,
  output logic [ERR_W-1:0] err_count,
  output logic             pass
`ifdef DDR_SEQ_FIRST_ERR_EN
  ,
  output logic             first_err_vld,
  output logic [LEN_W-1:0] first_err_idx
`endif
);

  localparam int WGT_W = $clog2(2 * WIDTH + 1);
  localparam int CLN_W = $clog2(LOCK_CYCLES + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ARM, SEED, LOCK, RUN, DONE} state_t;

  state_t           state;
  logic [4:0]       lfsr;
  logic [1:0]       seed_cnt;
  logic [CLN_W-1:0] clean_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [LEN_W-1:0] run_cnt;
  logic [LEN_W-1:0] len_q;

  function automatic logic [4:0] lfsr_step(input logic [4:0] l);
    return {l[3:0], ~(l[4] ^ l[2])};
  endfunction

  logic [4:0]       lfsr_1, lfsr_2, seed_shift;
  logic [WIDTH-1:0] rise_diff, fall_diff;
  logic [WGT_W-1:0] err_wgt;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] err_next;
  logic             clean, lock_hit, tmo_hit, run_last;

  // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    lfsr_1     = lfsr_step(lfsr);
    lfsr_2     = lfsr_step(lfsr_1);
    seed_shift = {lfsr[2:0], cap_rise[0], cap_fall[0]};
    rise_diff  = cap_rise ^ {WIDTH{lfsr[0]}};
    fall_diff  = cap_fall ^ {WIDTH{lfsr_1[0]}};
    err_wgt    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      err_wgt = err_wgt + WGT_W'(rise_diff[i]) + WGT_W'(fall_diff[i]);
    end
    // One extra bit catches overflow; a single capture can never add more than 2^ERR_W.
    err_sum  = (ERR_W + 1)'(err_count) + (ERR_W + 1)'(err_wgt);
    err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    clean    = (err_wgt == '0);
    lock_hit = clean && (clean_cnt == CLN_W'(LOCK_CYCLES - 1));
    tmo_hit  = (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));
    run_last = (run_cnt == LEN_W'(len_q - 1'b1));
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= '0;
      seed_cnt  <= '0;
      clean_cnt <= '0;
      tmo_cnt   <= '0;
      run_cnt   <= '0;
      len_q     <= '0;
      cap_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      locked    <= 1'b0;
      err_count <= '0;
      pass      <= 1'b0;
`ifdef DDR_SEQ_FIRST_ERR_EN
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= ARM;
          len_q     <= test_len;
          err_count <= '0;
          locked    <= 1'b0;
          done      <= 1'b0;
          pass      <= 1'b0;
          busy      <= 1'b1;
          cap_en    <= 1'b1;
`ifdef DDR_SEQ_FIRST_ERR_EN
          first_err_vld <= 1'b0;
          first_err_idx <= '0;
`endif
        end
        ARM: begin
          state     <= SEED;
          seed_cnt  <= '0;
          clean_cnt <= '0;
          tmo_cnt   <= '0;
        end
        SEED: if (cap_valid) begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (seed_cnt == 2'd2) begin
            // Step once past the last observed bit so l[0] predicts the next rise sample.
            lfsr     <= lfsr_step(seed_shift);
            seed_cnt <= '0;
            state    <= LOCK;
          end else begin
            lfsr     <= seed_shift;
            seed_cnt <= seed_cnt + 1'b1;
          end
          if (tmo_hit) begin
            state  <= DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
            cap_en <= 1'b0;
            pass   <= 1'b0;
          end
        end
        LOCK: if (cap_valid) begin
          lfsr    <= lfsr_2;
          tmo_cnt <= tmo_cnt + 1'b1;
          if (lock_hit) begin
            locked    <= 1'b1;
            clean_cnt <= '0;
            run_cnt   <= '0;
            if (len_q == '0) begin
              state  <= DONE;
              done   <= 1'b1;
              busy   <= 1'b0;
              cap_en <= 1'b0;
              pass   <= (err_count == '0);
            end else begin
              state <= RUN;
            end
          end else if (tmo_hit) begin
            state  <= DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
            cap_en <= 1'b0;
            pass   <= 1'b0;
          end else if (clean) begin
            clean_cnt <= clean_cnt + 1'b1;
          end else begin
            clean_cnt <= '0;
            seed_cnt  <= '0;
            state     <= SEED;
          end
        end
        RUN: if (cap_valid) begin
          lfsr      <= lfsr_2;
          err_count <= err_next;
          run_cnt   <= run_cnt + 1'b1;
`ifdef DDR_SEQ_FIRST_ERR_EN
          if (!clean && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= run_cnt;
          end
`endif
          if (run_last) begin
            state  <= DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
            cap_en <= 1'b0;
            pass   <= (err_next == '0);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
